// File: rtl/rx_buffer_ctrl_if.sv
// Receiver/host port bundle for rx_buffer_ctrl.
// The master side drives the push/pop/clear strobes; the slave side is the buffer.
interface rx_buffer_ctrl_if #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  load_buffer;
    logic [DATA_WIDTH-1:0] packet_data;
    logic                  data_read;
    logic                  err_clear;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  data_ready;
    logic                  overrun_error;
    logic [CW-1:0]         fifo_count;

    modport master (
        output load_buffer, packet_data, data_read, err_clear,
        input  rx_data, data_ready, overrun_error, fifo_count
    );

    modport slave (
        input  load_buffer, packet_data, data_read, err_clear,
        output rx_data, data_ready, overrun_error, fifo_count
    );
endinterface

// File: rtl/rx_buffer_ctrl.sv
// Circular receive FIFO between the UART receiver and the host read port, first-word fall-through.
// Optional macro RX_BUFFER_OVERWRITE_EN: a push into a full buffer replaces the oldest byte instead of being dropped.
module rx_buffer_ctrl #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          n_rst,
    rx_buffer_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overrun_q, overrun_d;

    logic full, empty;
    logic do_pop, do_push, overrun, overwrite;

    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        do_pop  = bus.data_read && !empty;
        // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
        do_push = bus.load_buffer && (!full || do_pop);
        overrun = bus.load_buffer && full && !do_pop;
`ifdef RX_BUFFER_OVERWRITE_EN
        overwrite = overrun;
`else
        overwrite = 1'b0;
`endif
    end

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun || (overrun_q && !bus.err_clear);

        if (do_push || overwrite) begin
            mem_d[wr_ptr_q] = bus.packet_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        // Overwrite drops the oldest byte by advancing the head alongside the write.
        if (do_pop || overwrite)
            rd_ptr_d = rd_ptr_q + PW'(1);

        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.rx_data       = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.data_ready    = !empty;
    assign bus.overrun_error = overrun_q;
    assign bus.fifo_count    = count_q;
endmodule

// File: doc/rx_buffer_ctrl.md
# rx_buffer_ctrl

Receive-buffer controller between the UART receiver control unit and the host read port. Each `load_buffer` strobe from the receiver captures `packet_data` into a small circular FIFO. The host pops bytes with `data_read`. The block tracks occupancy, presents the head byte with `data_ready`, and flags overrun when a byte arrives while the buffer is full.

## Interface
Parameters:
- `DEPTH`, default 4: number of byte entries. Must be a power of two, ≥2.
- `DATA_WIDTH`, default 8: byte width.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `load_buffer`  in  1: one-cycle strobe from the receiver; push `packet_data`.
- `packet_data`  in  DATA_WIDTH: received byte, valid while `load_buffer`=1.
- `data_read`  in  1: one-cycle host strobe; pop the head entry.
- `err_clear`  in  1: clears the `overrun_error` flag.
- `rx_data`  out  DATA_WIDTH: head entry; 0 when empty.
- `data_ready`  out  1: high when occupancy > 0.
- `overrun_error`  out  1: sticky overrun flag.
- `fifo_count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- **Storage:** DEPTH×DATA_WIDTH registers, with write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits wide. Both pointers wrap modulo DEPTH by natural overflow.
- **Occupancy counter:** `count` is the single source of truth. `full` = (count==DEPTH), `empty` = (count==0).
- **Push** (`load_buffer`=1, not full): mem[wr_ptr] ← packet_data; wr_ptr+1; count+1.
- **Pop** (`data_read`=1, not empty): rd_ptr+1; count−1.
- **Pop while empty:** ignored. No pointer or count change, no error.
- **Simultaneous push and pop:**
  - Not empty: both execute, count unchanged. This includes the full case, where the pop frees the slot, so there is no overrun.
  - Empty: the pop is ignored and the push executes; count becomes 1.
- **Push while full without pop:** the byte is dropped, pointers and count are unchanged, and `overrun_error` is set.
- **overrun_error:**
  - Set on the overrun condition above.
  - Cleared by `err_clear`.
  - If set and clear happen in the same cycle, set wins.
  - Pops never clear it.
- **Outputs:**
  - `data_ready` = !empty.
  - `rx_data` = mem[rd_ptr] when !empty, else 0. This is first-word fall-through.
  - `fifo_count` = count.
- **Reset** (n_rst=0, asynchronous): pointers=0, count=0, overrun_error=0, memory=0. Consequently rx_data=0, data_ready=0, fifo_count=0. Reset mid-operation discards all contents immediately.

## Timing
- All state updates happen on the rising `clk` edge. Outputs are combinational from registered state; there are no combinational paths from inputs to outputs.
- **Push latency:** a push in cycle N shows `data_ready`=1 and `rx_data`=byte in cycle N+1 (when the buffer was empty).
- **Pop latency:** a pop in cycle N shows the next entry, or empty, in cycle N+1.
- **Strobes:** single-cycle pulses. Holding a strobe high for k cycles performs k operations.
- **Overrun flag:** rises the cycle after the offending push. It falls the cycle after `err_clear`, provided no new overrun occurs in the clear cycle.
- **Throughput:** sustained 1 push and 1 pop per cycle.

## Configuration
- Macro: `RX_BUFFER_OVERWRITE_EN`.
- **Defined:** a push while full without pop overwrites the oldest entry:
  - mem[wr_ptr] ← packet_data; wr_ptr+1; rd_ptr+1; count stays DEPTH.
  - `overrun_error` is still set.
  - The head advances to the next-oldest byte.
- **Undefined (default):** the incoming byte is dropped as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** assert n_rst=0 mid-stream with count=3 → same cycle, all of the following: rx_data=0, data_ready=0, fifo_count=0, overrun_error=0. After release, a push of 0xA5 → next cycle rx_data=0xA5, count=1.
- **Ordering and wrap:**
  - Push 0x11, 0x22, 0x33, 0x44 → count=4.
  - Pop twice → rx_data=0x33.
  - Push 0x55, 0x66 (pointers wrap).
  - Pop four times → observed order 0x33, 0x44, 0x55, 0x66, then data_ready=0, rx_data=0.
- **Overrun, default build:**
  - With the buffer full of 0x01..0x04, push 0x99 → overrun_error=1, count=4, head=0x01.
  - Pops return 0x01..0x04; 0x99 is never seen.
  - Pulse err_clear → flag 0 next cycle.
- **Overrun, `RX_BUFFER_OVERWRITE_EN` defined:** same stimulus → overrun_error=1, count=4, head=0x02, pops return 0x02, 0x03, 0x04, 0x99.
- **Simultaneous events:**
  - Full, push 0x77 with pop → no overrun, count=4, head = former second entry.
  - Empty, push 0x42 with pop → count=1, rx_data=0x42.
  - Overrun and err_clear in the same cycle → overrun_error=1.
- **Pop on empty:** data_read with count=0 for 3 cycles → count stays 0, no error. A subsequent push 0x10 → rx_data=0x10.
